// File: rtl/lcd_fb_arbiter.sv
// Frame-buffer BRAM arbiter: display reads always win, writer words are posted
// into a small FIFO and committed in cycles without a display read.
module lcd_fb_arbiter #(
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned STARVE_MAX = 1023
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              pix_rd,
    input  logic [ADDR_W-1:0] pix_addr,
    output logic [DATA_W-1:0] pix_dout,
    output logic              pix_dvalid,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              fifo_empty,
    output logic              starve_err,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned WW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
    localparam logic [WW-1:0] STARVE_CNT = WW'(STARVE_MAX);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_PEND  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [WW-1:0]     wait_q, wait_d;
    logic              starve_q, starve_d;
    logic              en_q, en_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              rdv_q, rdv_d;
    logic              dvalid_q, dvalid_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              push, pop;

    assign wr_ready   = (count_q != FULL_CNT);
    assign fifo_empty = (state_q == ST_EMPTY);
    assign starve_err = starve_q;
    assign bram_en    = en_q;
    assign bram_we    = we_q;
    assign bram_addr  = addr_q;
    assign bram_din   = din_q;
    assign pix_dout   = dout_q;
    assign pix_dvalid = dvalid_q;

    // Grant selection, FIFO bookkeeping, state, starvation and read-return pipe
    always_comb begin
        push     = wr_valid & wr_ready;
        pop      = ~pix_rd & (count_q != '0);
        count_d  = count_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        state_d  = state_q;
        wait_d   = wait_q;
        starve_d = starve_q;
        en_d     = 1'b0;
        we_d     = 1'b0;
        addr_d   = addr_q;
        din_d    = din_q;

        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        if (pix_rd) begin
            en_d   = 1'b1;
            addr_d = pix_addr;
        end else if (pop) begin
            en_d   = 1'b1;
            we_d   = 1'b1;
            addr_d = fifo_addr_q[rptr_q];
            din_d  = fifo_data_q[rptr_q];
        end

        case (state_q)
            ST_EMPTY: if (push) state_d = ST_PEND;
            ST_PEND:  if (count_q == CW'(1) && pop && !push) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase

        if (state_q == ST_EMPTY || pop) begin
            wait_d = '0;
        end else if (pix_rd && wait_q != STARVE_CNT) begin
            wait_d = wait_q + 1'b1;
        end
        starve_d = starve_q | (wait_d == STARVE_CNT);

        // Read data is captured one cycle after the BRAM sampled the read,
        // so dvalid follows an issued read by two registers.
        rdv_d    = en_q & ~we_q;
        dvalid_d = rdv_q;
        dout_d   = rdv_q ? bram_dout : dout_q;
    end

    // Posted-write storage; entry validity is tracked by count_q, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wptr_q] <= wr_addr;
            fifo_data_q[wptr_q] <= wr_data;
        end
    end

    // State, pointers, BRAM command and display return registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_EMPTY;
            count_q  <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            wait_q   <= '0;
            starve_q <= 1'b0;
            en_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            rdv_q    <= 1'b0;
            dvalid_q <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            wait_q   <= wait_d;
            starve_q <= starve_d;
            en_q     <= en_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            rdv_q    <= rdv_d;
            dvalid_q <= dvalid_d;
            dout_q   <= dout_d;
        end
    end

endmodule
